// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor: one digit per clock, sign-magnitude difference.
// Optional input nibble validation with bcd_err output when BCD_CHECK_EN is defined.
module bcd_addsub_serial #(
    parameter int unsigned N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [4*N_DIGITS-1:0] a,
    input  logic [4*N_DIGITS-1:0] b,
    output logic                  busy,
    output logic                  valid,
    output logic [4*N_DIGITS+3:0] result,
    output logic                  neg
`ifdef BCD_CHECK_EN
    ,
    output logic                  bcd_err
`endif
);

    localparam int unsigned W     = 4 * N_DIGITS;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [W-1:0]     opa;
    logic [W-1:0]     opb;
    logic [W-1:0]     acc;
    logic             op_sub_q;
    logic             carry;
    logic             carry_dig;
    logic             neg_pend;
    logic [IDX_W-1:0] idx;

    logic [3:0]       nib_a_c;
    logic [3:0]       nib_b_c;
    logic [4:0]       sum_c;
    logic             carry_c;
    logic [3:0]       digit_c;
    logic [W-1:0]     acc_next_c;
    logic             last_c;

    // Shared BCD digit adder: CALC adds operand digits, FIX complements the accumulator digit
    always_comb begin
        nib_a_c = 4'd0;
        nib_b_c = 4'd0;
        if (state == FIX) begin
            nib_a_c = 4'(4'd9 - acc[3:0]);
        end else begin
            nib_a_c = opa[3:0];
            nib_b_c = op_sub_q ? 4'(4'd9 - opb[3:0]) : opb[3:0];
        end
        sum_c      = 5'(nib_a_c) + 5'(nib_b_c) + 5'(carry);
        carry_c    = (sum_c > 5'd9);
        digit_c    = carry_c ? 4'(sum_c + 5'd6) : sum_c[3:0];
        acc_next_c = (acc >> 4) | (W'(digit_c) << (W - 4));
        last_c     = (idx == IDX_W'(N_DIGITS - 1));
    end

`ifdef BCD_CHECK_EN
    logic bad_c;
    logic err_q;

    always_comb begin
        bad_c = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_c = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            op_sub_q  <= 1'b0;
            carry     <= 1'b0;
            carry_dig <= 1'b0;
            neg_pend  <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            result    <= '0;
            neg       <= 1'b0;
`ifdef BCD_CHECK_EN
            err_q     <= 1'b0;
            bcd_err   <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa      <= a;
                        opb      <= b;
                        op_sub_q <= op_sub;
                        carry    <= op_sub;
                        idx      <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
`ifdef BCD_CHECK_EN
                        err_q    <= bad_c;
`endif
                    end
                end
                CALC: begin
`ifdef BCD_CHECK_EN
                    if (err_q) state <= DONE;
                    else
`endif
                    begin
                        acc   <= acc_next_c;
                        opa   <= opa >> 4;
                        opb   <= opb >> 4;
                        carry <= carry_c;
                        idx   <= idx + IDX_W'(1);
                        if (last_c) begin
                            idx <= '0;
                            // A final borrow (no carry) on subtract means a<b: complement the result
                            if (op_sub_q && !carry_c) begin
                                carry_dig <= 1'b0;
                                neg_pend  <= 1'b1;
                                carry     <= 1'b1;
                                state     <= FIX;
                            end else begin
                                carry_dig <= op_sub_q ? 1'b0 : carry_c;
                                neg_pend  <= 1'b0;
                                state     <= DONE;
                            end
                        end
                    end
                end
                FIX: begin
                    acc   <= acc_next_c;
                    carry <= carry_c;
                    idx   <= idx + IDX_W'(1);
                    if (last_c) begin
                        idx   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                    result <= {3'b000, carry_dig, acc};
                    neg    <= neg_pend;
                    state  <= IDLE;
`ifdef BCD_CHECK_EN
                    bcd_err <= err_q;
                    if (err_q) begin
                        result <= '0;
                        neg    <= 1'b0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Randomized self-checking bench for bcd_addsub_serial against an integer-arithmetic model.
module tb_bcd_addsub_serial;

    localparam int unsigned N  = 3;
    localparam int unsigned W  = 4 * N;
    localparam int unsigned RW = W + 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op_sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          valid;
    logic [RW-1:0] result;
    logic          neg;
`ifdef BCD_CHECK_EN
    logic          bcd_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_addsub_serial #(.N_DIGITS(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .valid  (valid),
        .result (result),
        .neg    (neg)
`ifdef BCD_CHECK_EN
        ,
        .bcd_err(bcd_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd_val(input logic [W-1:0] x);
        int v = 0;
        for (int i = int'(N) - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [RW-1:0] to_bcd(input int v);
        logic [RW-1:0] r = '0;
        int t = v;
        for (int i = 0; i <= int'(N); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < int'(N); i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    function automatic logic [W-1:0] all_nines();
        logic [W-1:0] r = '0;
        for (int i = 0; i < int'(N); i++) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    // One complete operation: checks busy, latency, result, sign and hold behaviour
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic s,
                          input string tag);
        int va, vb, ev, lat, cyc;
        logic en;
        logic [RW-1:0] er;
        va = bcd_val(ta);
        vb = bcd_val(tb_op);
        if (!s) begin
            ev = va + vb; en = 1'b0; lat = int'(N) + 1;
        end else if (va >= vb) begin
            ev = va - vb; en = 1'b0; lat = int'(N) + 1;
        end else begin
            ev = vb - va; en = 1'b1; lat = 2 * int'(N) + 1;
        end
        er = to_bcd(ev);
        @(negedge clk);
        a = ta; b = tb_op; op_sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_hi"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!valid && cyc < 4 * int'(N) + 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_valid"}, 64'(valid), 64'd1);
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_neg"}, 64'(neg), 64'(en));
        check({tag, "_busy_lo"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, "_valid_pulse"}, 64'(valid), 64'd0);
        check({tag, "_result_hold"}, 64'(result), 64'(er));
    endtask

    initial begin
        int nv, first_v, second_v, third_v;
        logic [W-1:0] ra, rb;
        logic rs;

        reset = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_neg", 64'(neg), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(12'h999, 12'h001, 1'b0, "add_carry");
        run_op(12'h500, 12'h123, 1'b1, "sub_pos");
        run_op(12'h123, 12'h500, 1'b1, "sub_neg");
        run_op(12'h456, 12'h456, 1'b1, "sub_zero");
        run_op(all_nines(), all_nines(), 1'b0, "add_max");
        run_op(12'h000, 12'h999, 1'b1, "sub_min");

        // start pulses while busy must be ignored
        @(negedge clk);
        a = 12'h111; b = 12'h222; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0; first_v = -1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start = (cyc == 1 || cyc == 3);
            a = 12'h999; b = 12'h999;
            @(posedge clk); #1;
            if (valid) begin
                nv++;
                if (first_v < 0) first_v = cyc;
                check("busy_ign_result", 64'(result), 64'h0333);
            end
        end
        check("busy_ign_count", 64'(nv), 64'd1);
        check("busy_ign_lat", 64'(first_v), 64'(N + 1));

        // start held high: one op every latency+1 cycles
        @(negedge clk);
        a = 12'h250; b = 12'h125; op_sub = 1'b1; start = 1'b1;
        nv = 0; first_v = -1; second_v = -1; third_v = -1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(posedge clk); #1;
            if (valid) begin
                nv++;
                if (first_v < 0) first_v = cyc;
                else if (second_v < 0) second_v = cyc;
                else if (third_v < 0) third_v = cyc;
                check("held_result", 64'(result), 64'h0125);
            end
        end
        check("held_count", 64'(nv), 64'd3);
        check("held_first", 64'(first_v), 64'(N + 1));
        check("held_period", 64'(second_v - first_v), 64'(N + 2));
        check("held_period2", 64'(third_v - second_v), 64'(N + 2));
        @(negedge clk);
        start = 1'b0;
        repeat (2 * N + 4) @(posedge clk);

        // async reset in the middle of CALC discards the operation
        run_op(12'h123, 12'h500, 1'b1, "pre_rst");
        @(negedge clk);
        a = 12'h777; b = 12'h111; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(valid), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_neg", 64'(neg), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        nv = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        check("mid_rst_no_valid", 64'(nv), 64'd0);
        run_op(12'h250, 12'h250, 1'b0, "post_rst");

        // randomized operations with boundary biasing
        for (int i = 0; i < 150; i++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = all_nines();
                2: rb = all_nines();
                3: ra = '0;
                default: ;
            endcase
            run_op(ra, rb, rs, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
